// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit and the gshare predictor.
// Holds the predictor index width, the RISC-V control-flow opcodes, the
// resolve FSM state encoding and the layout of one in-flight queue entry.
package branch_resolve_unit_pkg;

  localparam int PRED_IDX_BITS = 8;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic {
    IDLE  = 1'b0,
    PULSE = 1'b1
  } bru_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
  } bru_entry_t;

  localparam int ENTRY_BITS = $bits(bru_entry_t);

  // Where fetch must restart once the real outcome of a branch is known.
  function automatic logic [31:0] redirect_target(input logic        taken,
                                                  input logic [31:0] target,
                                                  input logic [31:0] pc);
    return taken ? target : (pc + 32'd4);
  endfunction

  // A target mismatch only matters when both sides agree the branch was taken.
  function automatic logic is_mispredict(input bru_entry_t  e,
                                         input logic        taken,
                                         input logic [31:0] target);
    return (e.pred_taken != taken) ||
           (e.pred_taken && taken && (e.pred_target != target));
  endfunction

endpackage

// File: rtl/branch_resolve_unit_fifo.sv
// In-order queue of predicted branches awaiting resolution.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, wdata     write an entry at the tail (ignored when full)
//   pop             drop the head entry (ignored when empty)
//   clear           empty the queue; wins over push and pop in the same cycle
//   full, empty     status flags
//   count           number of stored entries (0..DEPTH)
//   head            oldest entry (meaningless while empty)
module branch_resolve_unit_fifo
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  bru_entry_t               wdata,
  input  logic                     pop,
  input  logic                     clear,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output bru_entry_t               head
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  bru_entry_t  mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/branch_resolve_unit.sv
// Back end of the gshare predictor interface. Queues predicted branches from
// IF, checks the oldest one against the EX resolution, strobes the predictor
// update, flushes with a redirect PC on a mispredict and counts outcomes.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   push_valid/ready, push_pc,
//   push_pred_taken/target           new predicted branch from IF
//   resolve_valid/ready,
//   resolve_taken/target             actual outcome of the oldest branch from EX
//   upd, upd_addr, upd_taken         one-cycle predictor update
//   flush, redirect_pc               one-cycle mispredict flush and restart PC
//   occupancy                        in-flight entries
//   branch_cnt, mispredict_cnt       saturating statistics
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int IDX_BITS = PRED_IDX_BITS,
  parameter int CNT_BITS = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_valid,
  output logic                    push_ready,
  input  logic [31:0]             push_pc,
  input  logic                    push_pred_taken,
  input  logic [31:0]             push_pred_target,
  input  logic                    resolve_valid,
  output logic                    resolve_ready,
  input  logic                    resolve_taken,
  input  logic [31:0]             resolve_target,
  output logic                    upd,
  output logic [IDX_BITS-1:0]     upd_addr,
  output logic                    upd_taken,
  output logic                    flush,
  output logic [31:0]             redirect_pc,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic [CNT_BITS-1:0]     branch_cnt,
  output logic [CNT_BITS-1:0]     mispredict_cnt
);

  bru_state_e state;
  bru_state_e state_next;

  bru_entry_t push_entry;
  bru_entry_t head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       accept;
  logic       mispredict;
  logic       mispredict_q;

  assign push_entry = '{pc: push_pc, pred_taken: push_pred_taken, pred_target: push_pred_target};

  // No pushes while flushing: anything IF offers then belongs to the wrong path.
  assign push_ready    = !fifo_full && !flush;
  assign resolve_ready = !fifo_empty && (state == IDLE);
  assign accept        = resolve_valid && resolve_ready;
  assign mispredict    = is_mispredict(head, resolve_taken, resolve_target);

  // A mispredict squashes every younger entry along with the head.
  branch_resolve_unit_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_valid && push_ready),
    .wdata (push_entry),
    .pop   (accept),
    .clear (accept && mispredict),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (occupancy),
    .head  (head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // PULSE always returns to IDLE, so upd has a low cycle between strobes.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = PULSE;
      PULSE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    upd   = 1'b0;
    flush = 1'b0;
    if (state == PULSE) begin
      upd   = 1'b1;
      flush = mispredict_q;
    end
  end

  // Update payload is captured at accept and held until the next resolution.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_addr       <= '0;
      upd_taken      <= 1'b0;
      redirect_pc    <= '0;
      mispredict_q   <= 1'b0;
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else if (accept) begin
      upd_addr     <= head.pc[IDX_BITS+1:2];
      upd_taken    <= resolve_taken;
      redirect_pc  <= redirect_target(resolve_taken, resolve_target, head.pc);
      mispredict_q <= mispredict;
      if (branch_cnt != '1)
        branch_cnt <= branch_cnt + 1'b1;
      if (mispredict && (mispredict_cnt != '1))
        mispredict_cnt <= mispredict_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit. Stimulus pushes hand-computed
// expected updates into a scoreboard queue; a negedge monitor pops one entry
// per upd strobe and compares the update payload.
module tb_branch_resolve_unit;

  logic        clk;
  logic        rst;
  logic        push_valid;
  logic        push_ready;
  logic [31:0] push_pc;
  logic        push_pred_taken;
  logic [31:0] push_pred_target;
  logic        resolve_valid;
  logic        resolve_ready;
  logic        resolve_taken;
  logic [31:0] resolve_target;
  logic        upd;
  logic [7:0]  upd_addr;
  logic        upd_taken;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [2:0]  occupancy;
  logic [15:0] branch_cnt;
  logic [15:0] mispredict_cnt;

  branch_resolve_unit dut (
    .clk              (clk),
    .rst              (rst),
    .push_valid       (push_valid),
    .push_ready       (push_ready),
    .push_pc          (push_pc),
    .push_pred_taken  (push_pred_taken),
    .push_pred_target (push_pred_target),
    .resolve_valid    (resolve_valid),
    .resolve_ready    (resolve_ready),
    .resolve_taken    (resolve_taken),
    .resolve_target   (resolve_target),
    .upd              (upd),
    .upd_addr         (upd_addr),
    .upd_taken        (upd_taken),
    .flush            (flush),
    .redirect_pc      (redirect_pc),
    .occupancy        (occupancy),
    .branch_cnt       (branch_cnt),
    .mispredict_cnt   (mispredict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic        taken;
    logic        flush;
    logic [31:0] redirect;
  } exp_t;

  exp_t sb[$];
  int   n_compared   = 0;
  int   n_mismatched = 0;
  int   upd_seen     = 0;
  logic prev_upd     = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every upd strobe must match the oldest expected update.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_upd = 1'b0;
    end else begin
      if (upd) begin
        upd_seen++;
        checkOutput("upd_gap", {31'd0, prev_upd}, 32'd0);
        if (sb.size() == 0) begin
          n_compared++;
          n_mismatched++;
          $display("[TB] FAIL unexpected_upd: got upd with addr 0x%0h, expected none", upd_addr);
        end else begin
          e = sb.pop_front();
          checkOutput("upd_addr", {24'd0, upd_addr}, {24'd0, e.addr});
          checkOutput("upd_taken", {31'd0, upd_taken}, {31'd0, e.taken});
          checkOutput("flush", {31'd0, flush}, {31'd0, e.flush});
          if (e.flush) checkOutput("redirect_pc", redirect_pc, e.redirect);
        end
      end
      prev_upd = upd;
    end
  end

  // Push one predicted branch; inputs change 1ns after the rising edge.
  task automatic applyStimulus(input logic [31:0] pc, input logic pred,
                               input logic [31:0] tgt);
    checkOutput("push_ready", {31'd0, push_ready}, 32'd1);
    push_valid       = 1'b1;
    push_pc          = pc;
    push_pred_taken  = pred;
    push_pred_target = tgt;
    @(posedge clk); #1;
    push_valid = 1'b0;
  endtask

  // Resolve the oldest branch and queue the hand-computed update; returns in cycle N+1.
  task automatic resolveBranch(input logic taken, input logic [31:0] tgt,
                               input logic [7:0] e_addr, input logic e_taken,
                               input logic e_flush, input logic [31:0] e_redir);
    int budget = 20;
    exp_t e;
    while (!resolve_ready && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (!resolve_ready) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL resolve_timeout: got resolve_ready=0, expected 1");
      return;
    end
    e.addr = e_addr; e.taken = e_taken; e.flush = e_flush; e.redirect = e_redir;
    sb.push_back(e);
    resolve_valid  = 1'b1;
    resolve_taken  = taken;
    resolve_target = tgt;
    @(posedge clk); #1;
    resolve_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    push_valid = 1'b0; push_pc = '0; push_pred_taken = 1'b0; push_pred_target = '0;
    resolve_valid = 1'b0; resolve_taken = 1'b0; resolve_target = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Test 1: reset state, then a resolve against an empty queue is ignored.
    checkOutput("rst_upd", {31'd0, upd}, 32'd0);
    checkOutput("rst_flush", {31'd0, flush}, 32'd0);
    checkOutput("rst_occupancy", {29'd0, occupancy}, 32'd0);
    checkOutput("rst_resolve_ready", {31'd0, resolve_ready}, 32'd0);
    checkOutput("rst_push_ready", {31'd0, push_ready}, 32'd1);
    checkOutput("rst_redirect_pc", redirect_pc, 32'd0);
    resolve_valid = 1'b1; resolve_taken = 1'b1; resolve_target = 32'h1234;
    repeat (3) @(posedge clk); #1;
    resolve_valid = 1'b0;
    checkOutput("empty_branch_cnt", {16'd0, branch_cnt}, 32'd0);

    // Test 2: correct taken prediction.
    applyStimulus(32'h100, 1'b1, 32'h140);
    checkOutput("t2_occupancy", {29'd0, occupancy}, 32'd1);
    resolveBranch(1'b1, 32'h140, 8'h40, 1'b1, 1'b0, 32'h0);
    checkOutput("t2_upd", {31'd0, upd}, 32'd1);
    checkOutput("t2_branch_cnt", {16'd0, branch_cnt}, 32'd1);
    checkOutput("t2_mispredict_cnt", {16'd0, mispredict_cnt}, 32'd0);
    checkOutput("t2_resolve_ready", {31'd0, resolve_ready}, 32'd0);
    @(posedge clk); #1;
    checkOutput("t2_upd_low", {31'd0, upd}, 32'd0);

    // Test 3: direction mispredict squashes younger entries and drops pushes at N and N+1.
    applyStimulus(32'h200, 1'b0, 32'h0);
    applyStimulus(32'h204, 1'b0, 32'h0);
    applyStimulus(32'h208, 1'b0, 32'h0);
    checkOutput("t3_occupancy", {29'd0, occupancy}, 32'd3);
    push_valid = 1'b1; push_pc = 32'h500; push_pred_taken = 1'b0; push_pred_target = '0;
    resolveBranch(1'b1, 32'h300, 8'h80, 1'b1, 1'b1, 32'h300);
    checkOutput("t3_flush", {31'd0, flush}, 32'd1);
    checkOutput("t3_redirect_pc", redirect_pc, 32'h300);
    checkOutput("t3_occupancy_n1", {29'd0, occupancy}, 32'd0);
    checkOutput("t3_push_ready_n1", {31'd0, push_ready}, 32'd0);
    checkOutput("t3_branch_cnt", {16'd0, branch_cnt}, 32'd2);
    checkOutput("t3_mispredict_cnt", {16'd0, mispredict_cnt}, 32'd1);
    @(posedge clk); #1;
    push_valid = 1'b0;
    checkOutput("t3_occupancy_n2", {29'd0, occupancy}, 32'd0);
    checkOutput("t3_flush_low", {31'd0, flush}, 32'd0);
    checkOutput("t3_redirect_hold", redirect_pc, 32'h300);

    // Test 4: predicted taken, actually not taken -> fall through to pc+4.
    applyStimulus(32'h80, 1'b1, 32'hC0);
    resolveBranch(1'b0, 32'h0, 8'h20, 1'b0, 1'b1, 32'h84);
    checkOutput("t4_redirect_pc", redirect_pc, 32'h84);
    checkOutput("t4_mispredict_cnt", {16'd0, mispredict_cnt}, 32'd2);
    @(posedge clk); #1;

    // Test 5: full queue, resolve held high -> four strobes, one every other cycle.
    applyStimulus(32'h400, 1'b0, 32'h0);
    applyStimulus(32'h404, 1'b0, 32'h0);
    applyStimulus(32'h408, 1'b0, 32'h0);
    applyStimulus(32'h40C, 1'b0, 32'h0);
    checkOutput("t5_occupancy_full", {29'd0, occupancy}, 32'd4);
    checkOutput("t5_push_ready_full", {31'd0, push_ready}, 32'd0);
    begin
      exp_t e;
      int   seen0;
      for (int i = 0; i < 4; i++) begin
        e.addr = 8'(i); e.taken = 1'b0; e.flush = 1'b0; e.redirect = '0;
        sb.push_back(e);
      end
      seen0 = upd_seen;
      resolve_valid = 1'b1; resolve_taken = 1'b0; resolve_target = '0;
      repeat (8) @(posedge clk); #1;
      checkOutput("t5_pulses", upd_seen - seen0, 32'd4);
    end
    checkOutput("t5_resolve_ready", {31'd0, resolve_ready}, 32'd0);
    checkOutput("t5_occupancy_empty", {29'd0, occupancy}, 32'd0);
    checkOutput("t5_branch_cnt", {16'd0, branch_cnt}, 32'd7);
    resolve_valid = 1'b0;
    @(posedge clk); #1;

    // Test 6: reset asserted mid-PULSE clears everything immediately.
    applyStimulus(32'h600, 1'b0, 32'h0);
    applyStimulus(32'h604, 1'b0, 32'h0);
    resolve_valid = 1'b1; resolve_taken = 1'b0; resolve_target = '0;
    @(posedge clk); #1;
    resolve_valid = 1'b0;
    checkOutput("t6_upd_before", {31'd0, upd}, 32'd1);
    checkOutput("t6_occupancy_before", {29'd0, occupancy}, 32'd1);
    checkOutput("t6_branch_cnt_before", {16'd0, branch_cnt}, 32'd8);
    rst = 1'b1;
    #1;
    checkOutput("t6_upd", {31'd0, upd}, 32'd0);
    checkOutput("t6_flush", {31'd0, flush}, 32'd0);
    checkOutput("t6_occupancy", {29'd0, occupancy}, 32'd0);
    checkOutput("t6_branch_cnt", {16'd0, branch_cnt}, 32'd0);
    checkOutput("t6_mispredict_cnt", {16'd0, mispredict_cnt}, 32'd0);
    checkOutput("t6_resolve_ready", {31'd0, resolve_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk); #1;

    checkOutput("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
